// File: rtl/uart_rx.sv
// 8N1 UART receiver with two-flop synchroniser, runtime bit period and frame/parity error strobes.
// Define UART_RX_PARITY_EN for 8E1 frames (even parity bit between data and stop).
module uart_rx #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] cycles_per_databit,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_parity_err,
  output logic [2:0] curr
);

`ifdef UART_RX_PARITY_EN
  localparam logic ParityEn = 1'b1;
`else
  localparam logic ParityEn = 1'b0;
`endif

  localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StParity   = 3'd3,
    StStop     = 3'd4,
    StWaitIdle = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_rx, s_rx_prev_q;
  logic [9:0]             timer_q, timer_d;
  logic [9:0]             period_q, period_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [7:0]             data_q, data_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   ferr_q, ferr_d;
  logic                   perr_q, perr_d;
  logic [9:0]             period_clamped;

  assign s_rx           = sync_q[SYNC_STAGES-1];
  assign period_clamped = (cycles_per_databit < 10'd4) ? 10'd4 : cycles_per_databit;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    period_d  = period_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s_rx_prev_q && !s_rx) begin
          state_d  = StStart;
          timer_d  = 10'd0;
          busy_d   = 1'b1;
          period_d = period_clamped;
        end
      end
      StStart: begin
        // Half-period check rejects glitches shorter than half a bit.
        if (timer_q == (period_q >> 1)) begin
          timer_d = 10'd0;
          if (!s_rx) begin
            state_d   = StData;
            bit_idx_d = 3'd0;
          end else begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end
        end else begin
          timer_d = timer_q + 10'd1;
        end
      end
      StData: begin
        if (timer_q == period_q - 10'd1) begin
          timer_d   = 10'd0;
          shift_d   = {s_rx, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LastBit) state_d = ParityEn ? StParity : StStop;
        end else begin
          timer_d = timer_q + 10'd1;
        end
      end
      StParity: begin
        if (timer_q == period_q - 10'd1) begin
          timer_d  = 10'd0;
          parity_d = s_rx;
          state_d  = StStop;
        end else begin
          timer_d = timer_q + 10'd1;
        end
      end
      StStop: begin
        if (timer_q == period_q - 10'd1) begin
          timer_d = 10'd0;
          if (s_rx) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            perr_d  = ParityEn && (parity_q != ^shift_q);
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitIdle;
          end
        end else begin
          timer_d = timer_q + 10'd1;
        end
      end
      StWaitIdle: begin
        // Hold off until the line returns high so a break cannot fake a start edge.
        if (s_rx) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q      <= '1;
      s_rx_prev_q <= 1'b1;
      state_q     <= StIdle;
      timer_q     <= 10'd0;
      period_q    <= 10'd4;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      parity_q    <= 1'b0;
      data_q      <= 8'd0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ferr_q      <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], rx_line};
      s_rx_prev_q <= s_rx;
      state_q     <= state_d;
      timer_q     <= timer_d;
      period_q    <= period_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      data_q      <= data_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ferr_q      <= ferr_d;
      perr_q      <= perr_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_done       = done_q;
  assign rx_busy       = busy_q;
  assign rx_frame_err  = ferr_q;
  assign rx_parity_err = perr_q;
  assign curr          = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives serial frames on rx_line and checks strobes, data and state.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif
  localparam int Cpd = 13;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] cycles_per_databit = 10'd13;
  logic       rx_line = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, rx_busy, rx_frame_err, rx_parity_err;
  logic [2:0] curr;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  logic [7:0] dq[$];

  uart_rx dut (
    .clk                (clk),
    .resetn             (resetn),
    .cycles_per_databit (cycles_per_databit),
    .rx_line            (rx_line),
    .rx_data            (rx_data),
    .rx_done            (rx_done),
    .rx_busy            (rx_busy),
    .rx_frame_err       (rx_frame_err),
    .rx_parity_err      (rx_parity_err),
    .curr               (curr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      dq.push_back(rx_data);
    end
    if (rx_frame_err) ferr_cnt++;
    if (rx_parity_err) perr_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    @(negedge clk) rx_line = v;
    repeat (Cpd - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (ParEn) drive_bit((^d) ^ flip_par);
    drive_bit(stop_v);
  endtask

  task automatic test_reset;
    resetn  = 1'b0;
    rx_line = 1'b1;
    idle(3);
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    total++; if (rx_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", rx_done); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
    total++; if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", rx_frame_err); end
    total++; if (rx_parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", rx_parity_err); end
    total++; if (curr !== 3'd0) begin bad++; $display("FAIL reset_curr got=%0d exp=0", curr); end
    resetn = 1'b1;
    idle(200);
    total++;
    if (done_cnt + ferr_cnt + perr_cnt != 0) begin
      bad++; $display("FAIL idle_strobes got=%0d exp=0", done_cnt + ferr_cnt + perr_cnt);
    end
  endtask

  task automatic test_loopback;
    int d0 = done_cnt, f0 = ferr_cnt, p0 = perr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'(8'h45 >> i));
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL lb_busy got=%b exp=1", rx_busy); end
    total++; if (curr !== 3'd2) begin bad++; $display("FAIL lb_curr got=%0d exp=2", curr); end
    for (int i = 3; i < 8; i++) drive_bit(1'(8'h45 >> i));
    if (ParEn) drive_bit(1'b1);
    drive_bit(1'b1);
    idle(10);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL lb_done got=%0d exp=1", done_cnt - d0); end
    total++; if (rx_data !== 8'h45) begin bad++; $display("FAIL lb_data got=%h exp=45", rx_data); end
    total++; if (ferr_cnt != f0) begin bad++; $display("FAIL lb_ferr got=%0d exp=0", ferr_cnt - f0); end
    total++; if (perr_cnt != p0) begin bad++; $display("FAIL lb_perr got=%0d exp=0", perr_cnt - p0); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL lb_busy_end got=%b exp=0", rx_busy); end
  endtask

  task automatic test_glitch;
    int d0 = done_cnt, f0 = ferr_cnt;
    @(negedge clk) rx_line = 1'b0;
    idle(3);
    total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL gl_busy_mid got=%b exp=1", rx_busy); end
    rx_line = 1'b1;
    idle(20);
    total++; if (curr !== 3'd0) begin bad++; $display("FAIL gl_curr got=%0d exp=0", curr); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL gl_busy got=%b exp=0", rx_busy); end
    total++;
    if ((done_cnt != d0) || (ferr_cnt != f0)) begin
      bad++; $display("FAIL gl_strobes got=%0d exp=0", (done_cnt - d0) + (ferr_cnt - f0));
    end
  endtask

  task automatic test_framing;
    int d0 = done_cnt, f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0, 1'b0);
    idle(50);
    total++; if (ferr_cnt - f0 != 1) begin bad++; $display("FAIL fr_ferr got=%0d exp=1", ferr_cnt - f0); end
    total++; if (rx_data !== 8'h45) begin bad++; $display("FAIL fr_data got=%h exp=45", rx_data); end
    total++; if (curr !== 3'd5) begin bad++; $display("FAIL fr_wait got=%0d exp=5", curr); end
    rx_line = 1'b1;
    idle(6);
    total++; if (curr !== 3'd0) begin bad++; $display("FAIL fr_idle got=%0d exp=0", curr); end
    total++; if (done_cnt != d0) begin bad++; $display("FAIL fr_done got=%0d exp=0", done_cnt - d0); end
    idle(20);
  endtask

  task automatic test_back_to_back;
    int d0 = done_cnt;
    int q0 = dq.size();
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(10);
    total++; if (done_cnt - d0 != 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", done_cnt - d0); end
    total++;
    if (dq.size() < q0 + 2) begin
      bad++; $display("FAIL b2b_data got=%0d_bytes exp=2_bytes", dq.size() - q0);
    end else if ((dq[q0] !== 8'h00) || (dq[q0+1] !== 8'hFF)) begin
      bad++; $display("FAIL b2b_data got=%h_%h exp=00_ff", dq[q0], dq[q0+1]);
    end
  endtask

  task automatic test_reset_mid_frame;
    int d0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'hF0 >> i));
    @(negedge clk) rx_line = 1'b1;
    idle(5);
    resetn = 1'b0;
    #1;
    total++; if (curr !== 3'd0) begin bad++; $display("FAIL rm_curr got=%0d exp=0", curr); end
    total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", rx_busy); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rm_data got=%h exp=00", rx_data); end
    idle(3);
    resetn = 1'b1;
    idle(20);
    d0 = done_cnt;
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(10);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL rm_done got=%0d exp=1", done_cnt - d0); end
    total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL rm_after got=%h exp=3c", rx_data); end
  endtask

  task automatic test_parity;
    int d0 = done_cnt, p0 = perr_cnt;
    if (ParEn) begin
      send_frame(8'h45, 1'b0, 1'b1);
      idle(10);
      total++; if (perr_cnt != p0) begin bad++; $display("FAIL par_good got=%0d exp=0", perr_cnt - p0); end
      send_frame(8'h45, 1'b1, 1'b1);
      idle(10);
      total++; if (perr_cnt - p0 != 1) begin bad++; $display("FAIL par_bad got=%0d exp=1", perr_cnt - p0); end
      total++; if (done_cnt - d0 != 2) begin bad++; $display("FAIL par_done got=%0d exp=2", done_cnt - d0); end
    end else begin
      total++; if (perr_cnt != 0) begin bad++; $display("FAIL par_off got=%0d exp=0", perr_cnt); end
    end
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_glitch;
    test_framing;
    test_back_to_back;
    test_reset_mid_frame;
    test_parity;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
